scan_chain_ctrl: RTL and testbench

- Drives the scan side of the mapped `dff` cells: `NbarT`, `Si` and `CE`, and reads the chain tail output.
- One test sequence: shift a parallel pattern into the chain serially, apply one functional capture clock, then shift the captured response out into a parallel register.
- Sits between the test host (register interface or JTAG bridge) and one scan chain of `dff` instances.

---
 rtl/scan_chain_ctrl.sv | 78 +++++++
 tb/tb_scan_chain_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: shift/capture/unload sequencer for one dff scan chain; `define SCAN_MISR_EN adds a 16-bit response MISR
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 global_resetbar,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response_out,
  output logic                 NbarT,
  output logic                 Si,
  output logic                 chain_ce,
  input  logic                 So
`ifdef SCAN_MISR_EN
  ,
  output logic [15:0]          signature
`endif
);
  localparam int IW = $clog2(CHAIN_LEN);
  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CHAIN_LEN-1:0] pat;
  logic [IW-1:0] si_idx, rsp_idx;
  logic last, accept, si_d, nbart_d, ce_d;
  assign last = cnt == CNT_W'(CHAIN_LEN - 1);
  assign accept = state == IDLE && start;
  always_ff @(posedge clk or negedge global_resetbar)
    if (!global_resetbar) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_d;
    end
  always_comb begin
    nxt = accept ? SHIFT :
          state == SHIFT ? (last ? CAPTURE : SHIFT) :
          state == CAPTURE ? UNLOAD :
          state == UNLOAD ? (last ? DONE : UNLOAD) : IDLE;
    cnt_d = ((state == SHIFT || state == UNLOAD) && !last) ? cnt + CNT_W'(1) : '0;
  end
  always_comb begin
    si_idx = IW'(CHAIN_LEN - 2) - cnt[IW-1:0];
    rsp_idx = IW'(CHAIN_LEN - 1) - cnt[IW-1:0];
    si_d = accept ? pattern_in[CHAIN_LEN-1] : (state == SHIFT && !last) ? pat[si_idx] : 1'b0;
    nbart_d = nxt == SHIFT || nxt == UNLOAD;
    ce_d = nbart_d || nxt == CAPTURE;
  end
  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk or negedge global_resetbar)
    if (!global_resetbar) begin
      busy <= 1'b0;
      done <= 1'b0;
      NbarT <= 1'b0;
      Si <= 1'b0;
      chain_ce <= 1'b0;
      pat <= '0;
      response_out <= '0;
    end else begin
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      NbarT <= nbart_d;
      Si <= si_d;
      chain_ce <= ce_d;
      if (accept) pat <= pattern_in;
      if (state == UNLOAD) response_out[rsp_idx] <= So;
    end
`ifdef SCAN_MISR_EN
  always_ff @(posedge clk or negedge global_resetbar)
    if (!global_resetbar) signature <= '0;
    else if (accept) signature <= '0;
    else if (state == UNLOAD) signature <= {signature[14:0], 1'b0} ^ ({16{signature[15] ^ So}} & 16'h1021);
`endif
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: scoreboard bench driving scan_chain_ctrl against a behavioural 8-flop chain
module tb_scan_chain_ctrl;
  localparam int N = 8;
  logic clk = 0, rst_n = 0, start = 0, so;
  logic [N-1:0] pattern_in = '0, response_out;
  logic busy, done, NbarT, Si, chain_ce;
`ifdef SCAN_MISR_EN
  logic [15:0] signature;
`endif
  logic [N-1:0] chain = '0;
  bit inv = 0;
  int checks = 0, failures = 0, cyc = 0, dones = 0;
  logic [N-1:0] sb[$];

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk(clk), .global_resetbar(rst_n), .start(start), .pattern_in(pattern_in),
    .busy(busy), .done(done), .response_out(response_out), .NbarT(NbarT),
    .Si(Si), .chain_ce(chain_ce), .So(so)
`ifdef SCAN_MISR_EN
    , .signature(signature)
`endif
  );

  always #5 clk = ~clk;
  assign so = chain[N-1];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    dones <= dones + int'(done);
    if (chain_ce) chain <= NbarT ? {chain[N-2:0], Si} : (inv ? ~chain : chain);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] misr_ref(input logic [N-1:0] r);
    logic [15:0] s = '0;
    for (int k = 0; k < N; k++) s = {s[14:0], 1'b0} ^ ({16{s[15] ^ r[N-1-k]}} & 16'h1021);
    return s;
  endfunction

  task automatic run(input logic [N-1:0] p, input bit inv_m, input int inj);
    int c = 1, nb0 = 0, sibad = 0, cebad = 0;
    inv = inv_m;
    pattern_in = p;
    start = 1;
    tick;
    start = 0;
    sb.push_back(inv_m ? ~p : p);
    while (!done && c <= 3 * N) begin
      if (busy && chain_ce && !NbarT) nb0++;
      if (c >= N + 2 && Si) sibad++;
      if (!busy || !chain_ce) cebad++;
      start = c == inj;
      if (c == inj) pattern_in = '1;
      tick;
      c++;
    end
    start = 0;
    check("latency", 32'(c), 32'(2 * N + 2));
    check("done", 32'(done), 1);
    check("response", 32'(response_out), 32'(sb.pop_front()));
    check("capture_cycles", 32'(nb0), 1);
    check("si_unload_zero", 32'(sibad), 0);
    check("ce_busy", 32'(cebad), 0);
    tick;
    check("done_pulse", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int c, d1, d0;
    repeat (2) tick;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_nbart", 32'(NbarT), 0);
    check("rst_ce", 32'(chain_ce), 0);
    check("rst_si", 32'(Si), 0);
    check("rst_resp", 32'(response_out), 0);
    rst_n = 1;
    tick;
    run(8'hA5, 0, 0);
    // abort in the middle of UNLOAD
    inv = 0;
    pattern_in = 8'h55;
    start = 1;
    tick;
    start = 0;
    sb.push_back(8'h55);
    repeat (N + 3) tick;
    check("pre_rst_nbart", 32'(NbarT), 1);
    rst_n = 0;
    #1;
    check("mid_rst_nbart", 32'(NbarT), 0);
    check("mid_rst_ce", 32'(chain_ce), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_resp", 32'(response_out), 0);
    sb.delete();
    #2 rst_n = 1;
    tick;
    check("post_rst_idle", 32'(busy), 0);
    run(8'hA5, 0, 0);
    run(8'h3C, 1, 0);
    check("chain_zero", 32'(chain), 0);
    d0 = dones;
    run(8'h01, 0, 3);
    repeat (2 * N + 4) tick;
    check("busy_start_one_done", 32'(dones - d0), 1);
    // start held high across two sequences
    inv = 0;
    pattern_in = 8'h81;
    start = 1;
    tick;
    pattern_in = 8'h7E;
    sb.push_back(8'h81);
    c = 1;
    while (!done && c <= 3 * N) begin tick; c++; end
    d1 = cyc;
    check("b2b_resp1", 32'(response_out), 32'(sb.pop_front()));
    tick;
    check("b2b_idle_gap", 32'(busy), 0);
    sb.push_back(8'h7E);
    tick;
    check("b2b_shift_nbart", 32'(NbarT), 1);
    check("b2b_shift_busy", 32'(busy), 1);
    start = 0;
    c = 1;
    while (!done && c <= 3 * N) begin tick; c++; end
    check("b2b_done_gap", 32'(cyc - d1), 19);
    check("b2b_resp2", 32'(response_out), 32'(sb.pop_front()));
`ifdef SCAN_MISR_EN
    run(8'h00, 0, 0);
    check("sig_zero", 32'(signature), 0);
    run(8'h80, 0, 0);
    check("sig_80_a", 32'(signature), 32'(misr_ref(8'h80)));
    run(8'h80, 0, 0);
    check("sig_80_b", 32'(signature), 32'(misr_ref(8'h80)));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
